// File: rtl/padder_576.sv
`default_nettype none
// ============================================================================
// Module   : padder_576
// Purpose  : Keccak/SHA3 partial-block padder for a 576-bit rate (72 bytes).
//            Keeps the first byte_num message bytes of the word, places the
//            domain-separation byte right after them and zero-fills the rest.
//            The final 0x80 bit is added by the next stage, not here.
//            Result is registered (one cycle latency, full throughput).
// Ports    : clk       - system clock, rising edge
//            rst_n     - asynchronous active-low reset
//            in        - message word, byte 0 = in[575:568] (MSB-first)
//            byte_num  - number of valid message bytes, counted from byte 0
//            in_valid  - capture in/byte_num this cycle
//            out       - padded word (registered)
//            out_valid - one-cycle pulse per accepted input
// Options  : PADDER_SHAKE_EN - pad byte 8'h1F (SHAKE) instead of 8'h06 (SHA3)
// Revision : 1.0 - initial release
// ============================================================================
module padder_576 #(
  parameter int RATE_BITS = 576,
  parameter int NUM_BYTES = RATE_BITS / 8,
  parameter int BN_W      = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RATE_BITS-1:0] in,
  input  logic [BN_W-1:0]      byte_num,
  input  logic                 in_valid,
  output logic [RATE_BITS-1:0] out,
  output logic                 out_valid
);

`ifdef PADDER_SHAKE_EN
  localparam logic [7:0] c_PAD_BYTE = 8'h1F;
`else
  localparam logic [7:0] c_PAD_BYTE = 8'h06;
`endif

  logic [RATE_BITS-1:0] w_padded;
  logic [RATE_BITS-1:0] r_out;
  logic                 r_out_valid;

  // Each output byte is an independent full compare of byte_num against its
  // own index, so any byte_num value (including >= NUM_BYTES, where every
  // byte is below byte_num and the word passes through) yields a defined byte.
  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_byte
    localparam logic [BN_W-1:0] c_IDX = BN_W'(k);
    localparam int              c_MSB = RATE_BITS - 1 - 8 * k;

    assign w_padded[c_MSB -: 8] = (byte_num > c_IDX)  ? in[c_MSB -: 8] :
                                  (byte_num == c_IDX) ? c_PAD_BYTE     :
                                                        8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out <= w_padded;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_padder_576.sv
`default_nettype none
// ============================================================================
// Module   : tb_padder_576
// Purpose  : Self-checking bench for padder_576. Directed boundary cases plus
//            randomized traffic compared against a byte-level reference model.
// Options  : PADDER_SHAKE_EN - selects the SHAKE pad byte in the model too
// Revision : 1.0 - initial release
// ============================================================================
module tb_padder_576;

`ifdef PADDER_SHAKE_EN
  localparam logic [7:0]  c_PB      = 8'h1F;
  localparam logic [63:0] c_TOP_BN3 = 64'h90ABCD1F00000000;
`else
  localparam logic [7:0]  c_PB      = 8'h06;
  localparam logic [63:0] c_TOP_BN3 = 64'h90ABCD0600000000;
`endif

  logic         clk;
  logic         rst_n;
  logic [575:0] in;
  logic [10:0]  byte_num;
  logic         in_valid;
  logic [575:0] out;
  logic         out_valid;

  int n_vec;
  int n_err;

  logic [575:0] base;
  logic [575:0] exp_out;
  logic         exp_valid;

  padder_576 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .byte_num  (byte_num),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [575:0] got, input logic [575:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: build the padded word as a list of 72 bytes, then pack it.
  function automatic logic [575:0] pad_model(input logic [575:0] msg, input int bn);
    logic [7:0]   bytes [72];
    logic [575:0] res;
    for (int k = 0; k < 72; k++) begin
      if (k < bn)       bytes[k] = msg[575 - 8 * k -: 8];
      else if (k == bn) bytes[k] = c_PB;
      else              bytes[k] = 8'h00;
    end
    res = '0;
    for (int k = 0; k < 72; k++) res = {res[567:0], bytes[k]};
    return res;
  endfunction

  function automatic logic [575:0] rand_word();
    logic [575:0] w;
    w = '0;
    for (int i = 0; i < 18; i++) w = {w[543:0], 32'($urandom)};
    return w;
  endfunction

  // Apply one cycle of input, advance past the edge, check both outputs.
  task automatic apply(input string tag, input logic v, input logic [575:0] d, input int bn);
    in       = d;
    byte_num = 11'(bn);
    in_valid = v;
    @(posedge clk);
    #1;
    if (v) exp_out = pad_model(d, bn);
    exp_valid = v;
    check({tag, "_out"}, out, exp_out);
    check({tag, "_vld"}, {575'd0, out_valid}, {575'd0, exp_valid});
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    exp_out   = '0;
    exp_valid = 1'b0;
    base      = {9{64'h90ABCDEF11111111}};

    // Reset held with active traffic: outputs stay cleared.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    byte_num = 11'd5;
    in       = rand_word();
    #2;
    for (int i = 0; i < 4; i++) begin
      in = rand_word();
      @(posedge clk);
      #1;
      check("rst_out", out, '0);
      check("rst_vld", {575'd0, out_valid}, 576'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    apply("idle_after_rst", 1'b0, rand_word(), 3);

    // Directed cases on the fixed pattern word.
    apply("bn3", 1'b1, base, 3);
    check("bn3_top", {512'd0, out[575:512]}, {512'd0, c_TOP_BN3});
    check("bn3_low", {64'd0, out[511:0]}, 576'd0);
    apply("bn3_pulse", 1'b0, base, 3);
    apply("bn0", 1'b1, base, 0);
    check("bn0_const", out, {c_PB, 568'd0});
    apply("bn71", 1'b1, base, 71);
    check("bn71_const", out, {base[575:8], c_PB});
    apply("bn72", 1'b1, base, 72);
    check("bn72_pass", out, base);
    apply("bn2047", 1'b1, base, 2047);
    check("bn2047_pass", out, base);

    // Back-to-back, then hold.
    apply("b2b8", 1'b1, rand_word(), 8);
    apply("b2b16", 1'b1, rand_word(), 16);
    apply("b2b64", 1'b1, rand_word(), 64);
    apply("hold", 1'b0, rand_word(), 5);
    apply("hold2", 1'b0, rand_word(), 0);

    // Random traffic, byte_num biased toward the interesting range.
    for (int i = 0; i < 300; i++) begin
      int bn;
      bn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 75));
      apply("rand", ($urandom_range(0, 3) != 0), rand_word(), bn);
    end

    // Mid-stream asynchronous reset clears outputs without a clock edge.
    apply("pre_rst", 1'b1, rand_word(), 40);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", out, '0);
    check("async_rst_vld", {575'd0, out_valid}, 576'd0);
    exp_out   = '0;
    exp_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_out", out, '0);
    rst_n = 1'b1;
    apply("post_rst", 1'b1, base, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
